lsu_ahb_sbuf: RTL and testbench
===============================

// Module: lsu_ahb_sbuf
// PURPOSE
//  Parametrised load/store unit for the EX stage: issues single AHB-Lite data transfers and buffers stores
//  in a posted-write FIFO so the pipeline only stalls on a full buffer or a load.
//  Loads drain the buffer first, then return byte/half/word data, aligned and sign/zero-extended, on a
//  registered writeback port. Sits between EX address generation and the data AHB master port.
// PARAMETERS
//  XLEN      32  data/address width (only 32 supported on AHB side)
//  RF_IDX_W  5   register-file index width
//  SB_DEPTH  4   store-buffer entries (power of 2, >=2)
// PORTS
//  clk         in   1         core clock
//  rst_n       in   1         asynchronous active-low reset
//  req_valid   in   1         EX presents a load/store this cycle
//  req_ready   out  1         request accepted when req_valid&req_ready; low = pipeline stall
//  req_write   in   1         1=store, 0=load
//  req_size    in   2         0=byte 1=half 2=word
//  req_uns     in   1         load zero-extends when 1
//  req_addr    in   XLEN      effective address
//  req_wdata   in   XLEN      store data (rs2, unshifted)
//  req_rd      in   RF_IDX_W  load destination register
//  wb_en       out  1         load writeback strobe (never for rd==0)
//  wb_rd       out  RF_IDX_W  load destination
//  wb_data     out  XLEN      extended load data
//  bus_err     out  1         one-cycle pulse on AHB ERROR response
//  sb_empty    out  1         store buffer empty (fence support)
//  d_haddr/d_htrans/d_hwrite/d_hsize/d_hburst/d_hprot/d_hwdata  out  AHB master address/data phase
//  d_hrdata in 32, d_hready in 1, d_hresp in 1
// BEHAVIOUR
//  Reset: htrans=IDLE, all AHB outs 0, hburst=SINGLE, hprot=4'b0011, wb_en=0, bus_err=0, sb empty, FSM IDLE.
//  Stores: accepted when buffer not full (req_ready=~full), pushed same cycle; zero added latency.
//  Loads: req_ready=1 only when sb_empty & FSM IDLE; otherwise stall until drained (no forwarding).
//  FSM IDLE -> ADDR: drives NONSEQ + haddr/hsize/hwrite for one cycle while hready high; buffer head has
//   priority over a waiting load (always true: loads require empty buffer).
//  ADDR -> DATA when hready; ADDR holds signals while hready low. DATA: hwdata = store data replicated to
//   byte lanes; wait while hready low; hready&~hresp -> IDLE (store pops). Back-to-back stores may pipeline:
//   next NONSEQ issued in DATA cycle of previous (ADDR/DATA overlap).
//  Load complete: next cycle wb_en=1 (if rd!=0), data = lane select by addr[1:0], extend per size/uns.
//   Load latency = 3 cycles min from acceptance to wb_en.
//  hresp=1 (first ERROR cycle): htrans driven IDLE next cycle, bus_err pulses, store popped/load writeback
//   suppressed, FSM -> IDLE.
//  Simultaneous push and pop: count unchanged; full & pop same cycle still deasserts req_ready (no bypass).
//  Pointers wrap modulo SB_DEPTH; occupancy counter log2(SB_DEPTH)+1 bits.
//  Reset mid-transfer: immediate IDLE, buffer contents discarded.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined: misaligned half/word request is accepted but no bus transfer,
//   bus_err pulses next cycle, no writeback. Undefined: addr low bits forced to natural alignment
//   (half: addr[0]=0, word: addr[1:0]=0) and transfer proceeds.
// STRUCTURE
//  Shared defines (risc_v_defines.vh): HTRANS_IDLE/NONSEQ, HSIZE_B/H/W, LSU FSM state encodings,
//   store-buffer entry layout {addr,size,wdata}.
//  Sub-module lsu_sbuf_fifo: SB_DEPTH x entry FIFO with push/pop/full/empty; top holds FSM and lane logic.
// TESTING
//  Store word 0xDEADBEEF @0x100, hready=1 -> NONSEQ write, hsize=2, hwdata 0xDEADBEEF, sb_empty after 2 cyc.
//  5 stores, SB_DEPTH=4, hready held low -> req_ready low on 5th until first pop; order preserved.
//  Store then load @0x101 byte signed, mem=0x0000_8000 -> load stalls until drain, wb_data=0xFFFFFF80.
//  Load half uns @0x102, hrdata=0xABCD1234 -> wb_data=0x0000ABCD, wb_en 1 cycle, rd=0 -> no wb_en.
//  hresp=1 on store -> bus_err 1 cycle, htrans IDLE, buffer pops, next store proceeds.
//  Word load @0x103: with LSU_MISALIGN_TRAP_EN -> bus_err, no transfer; without -> haddr=0x100.

Source files
------------

// File: rtl/lsu_ahb_sbuf_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : lsu_ahb_sbuf_pkg
// Brief  : Shared AHB encodings, LSU FSM states, store-buffer entry layout
//          and lane/alignment helpers for the load/store unit.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
package lsu_ahb_sbuf_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HSIZE_B       = 2'd0;
  localparam logic [1:0] HSIZE_H       = 2'd1;
  localparam logic [1:0] HSIZE_W       = 2'd2;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DATA    = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } lsu_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
  } sb_entry_t;

  // The reserved size code 3 is handled as a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == 2'd3) ? HSIZE_W : size;
  endfunction

  function automatic logic [31:0] align_addr(input logic [31:0] addr, input logic [1:0] size);
    logic [31:0] a;
    a = addr;
    if (size == HSIZE_H) a[0] = 1'b0;
    else if (size == HSIZE_W) a[1:0] = 2'b00;
    return a;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] off, input logic [1:0] size);
    return ((size == HSIZE_H) && off[0]) || ((size == HSIZE_W) && (off != 2'b00));
  endfunction

  function automatic logic [31:0] lane_replicate(input logic [31:0] wdata, input logic [1:0] size);
    case (size)
      HSIZE_B: return {4{wdata[7:0]}};
      HSIZE_H: return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] rdata, input logic [1:0] off,
                                              input logic [1:0] size, input logic uns);
    logic [31:0] sh;
    sh = rdata >> {off, 3'b000};
    case (size)
      HSIZE_B: return uns ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      HSIZE_H: return uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: return rdata;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_ahb_sbuf_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : lsu_ahb_sbuf_fifo
// Brief  : Posted-write store buffer, DEPTH entries, show-ahead head output.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
module lsu_ahb_sbuf_fifo #(
  parameter int WIDTH = 66,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/lsu_ahb_sbuf.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : lsu_ahb_sbuf
// Brief  : EX-stage load/store unit with posted-write store buffer on an
//          AHB-Lite data master. Build option LSU_MISALIGN_TRAP_EN turns
//          misaligned half/word requests into bus errors instead of aligning.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
module lsu_ahb_sbuf
  import lsu_ahb_sbuf_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int RF_IDX_W = 5,
  parameter int SB_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [1:0]          req_size,
  input  logic                req_uns,
  input  logic [XLEN-1:0]     req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  input  logic [RF_IDX_W-1:0] req_rd,
  output logic                wb_en,
  output logic [RF_IDX_W-1:0] wb_rd,
  output logic [XLEN-1:0]     wb_data,
  output logic                bus_err,
  output logic                sb_empty,
  output logic [31:0]         d_haddr,
  output logic [1:0]          d_htrans,
  output logic                d_hwrite,
  output logic [2:0]          d_hsize,
  output logic [2:0]          d_hburst,
  output logic [3:0]          d_hprot,
  output logic [31:0]         d_hwdata,
  input  logic [31:0]         d_hrdata,
  input  logic                d_hready,
  input  logic                d_hresp
);

  lsu_state_e          state_q, state_d;
  logic [1:0]          htrans_q, htrans_d;
  logic [31:0]         haddr_q, haddr_d;
  logic                hwrite_q, hwrite_d;
  logic [1:0]          hsize_q, hsize_d;
  logic [31:0]         hwdata_q, hwdata_d;
  logic [RF_IDX_W-1:0] ld_rd_q, ld_rd_d;
  logic                ld_uns_q, ld_uns_d;
  logic                wb_en_q, wb_en_d;
  logic [RF_IDX_W-1:0] wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]     wb_data_q, wb_data_d;
  logic                bus_err_q, bus_err_d;

  sb_entry_t   head, push_entry;
  logic        sb_full, sb_empty_w, push, pop, accept, trap;
  logic [1:0]  req_size_n;
  logic [31:0] req_addr_a;

  lsu_ahb_sbuf_fifo #(
    .WIDTH ($bits(sb_entry_t)),
    .DEPTH (SB_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head),
    .full      (sb_full),
    .empty     (sb_empty_w)
  );

  assign req_size_n = norm_size(req_size);
  assign req_addr_a = align_addr(req_addr, req_size_n);

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = is_misaligned(req_addr[1:0], req_size_n);
`else
  assign trap = 1'b0;
`endif

  // Loads see no forwarding, so they wait until every posted store has retired.
  assign req_ready  = req_write ? ~sb_full : (sb_empty_w & (state_q == ST_IDLE));
  assign accept     = req_valid & req_ready;
  assign push       = accept & req_write & ~trap;
  assign push_entry = '{addr: req_addr_a, size: req_size_n, wdata: req_wdata};

  always_comb begin
    state_d   = state_q;
    htrans_d  = htrans_q;
    haddr_d   = haddr_q;
    hwrite_d  = hwrite_q;
    hsize_d   = hsize_q;
    hwdata_d  = hwdata_q;
    ld_rd_d   = ld_rd_q;
    ld_uns_d  = ld_uns_q;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    wb_en_d   = 1'b0;
    bus_err_d = accept & trap;
    pop       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!sb_empty_w) begin
          htrans_d = HTRANS_NONSEQ;
          haddr_d  = head.addr;
          hsize_d  = head.size;
          hwrite_d = 1'b1;
          state_d  = ST_ADDR;
        end else if (accept && !trap) begin
          // Empty buffer: launch straight from the request; a store is also pushed
          // so that it becomes the head that the data phase and the pop refer to.
          htrans_d = HTRANS_NONSEQ;
          haddr_d  = req_addr_a;
          hsize_d  = req_size_n;
          hwrite_d = req_write;
          ld_rd_d  = req_rd;
          ld_uns_d = req_uns;
          state_d  = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (d_hready) begin
          htrans_d = HTRANS_IDLE;
          state_d  = ST_DATA;
          if (hwrite_q) hwdata_d = lane_replicate(head.wdata, head.size);
        end
      end
      ST_DATA: begin
        if (d_hresp) begin
          bus_err_d = 1'b1;
          pop       = hwrite_q;
          state_d   = ST_IDLE;
        end else if (d_hready) begin
          state_d = ST_IDLE;
          if (hwrite_q) begin
            pop = 1'b1;
          end else begin
            wb_en_d   = |ld_rd_q;
            wb_rd_d   = ld_rd_q;
            wb_data_d = load_extend(d_hrdata, haddr_q[1:0], hsize_q, ld_uns_q);
          end
        end
      end
      default: begin
        htrans_d = HTRANS_IDLE;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      htrans_q  <= HTRANS_IDLE;
      haddr_q   <= '0;
      hwrite_q  <= 1'b0;
      hsize_q   <= '0;
      hwdata_q  <= '0;
      ld_rd_q   <= '0;
      ld_uns_q  <= 1'b0;
      wb_en_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      htrans_q  <= htrans_d;
      haddr_q   <= haddr_d;
      hwrite_q  <= hwrite_d;
      hsize_q   <= hsize_d;
      hwdata_q  <= hwdata_d;
      ld_rd_q   <= ld_rd_d;
      ld_uns_q  <= ld_uns_d;
      wb_en_q   <= wb_en_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign d_htrans = htrans_q;
  assign d_haddr  = haddr_q;
  assign d_hwrite = hwrite_q;
  assign d_hsize  = {1'b0, hsize_q};
  assign d_hburst = HBURST_SINGLE;
  assign d_hprot  = HPROT_DATA;
  assign d_hwdata = hwdata_q;
  assign wb_en    = wb_en_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;
  assign bus_err  = bus_err_q;
  assign sb_empty = sb_empty_w;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ahb_sbuf.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : tb_lsu_ahb_sbuf
// Brief  : Directed scoreboard bench for lsu_ahb_sbuf (honours LSU_MISALIGN_TRAP_EN).
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
module tb_lsu_ahb_sbuf;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_write, req_uns;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        wb_en, bus_err, sb_empty;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] d_haddr, d_hwdata, d_hrdata;
  logic [1:0]  d_htrans;
  logic        d_hwrite, d_hready, d_hresp;
  logic [2:0]  d_hsize, d_hburst;
  logic [3:0]  d_hprot;

  int checks = 0, errors = 0, wb_seen = 0, err_seen = 0;

  typedef struct packed { logic [31:0] addr; logic wr; logic [1:0] size; } addr_exp_t;
  typedef struct packed { logic [4:0] rd; logic [31:0] data; } wb_exp_t;
  addr_exp_t   addr_q[$];
  logic [31:0] wdata_q[$];
  wb_exp_t     wb_q[$];

  lsu_ahb_sbuf #(.XLEN(32), .RF_IDX_W(5), .SB_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_uns(req_uns), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .bus_err(bus_err), .sb_empty(sb_empty),
    .d_haddr(d_haddr), .d_htrans(d_htrans), .d_hwrite(d_hwrite), .d_hsize(d_hsize),
    .d_hburst(d_hburst), .d_hprot(d_hprot), .d_hwdata(d_hwdata),
    .d_hrdata(d_hrdata), .d_hready(d_hready), .d_hresp(d_hresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: address phases, store data phases and writebacks pop expectations.
  logic pend_d, pend_wr;
  addr_exp_t   m_a;
  wb_exp_t     m_w;
  logic [31:0] m_d;
  initial begin pend_d = 1'b0; pend_wr = 1'b0; end
  always @(negedge clk) begin
    if (!rst_n) begin
      pend_d = 1'b0;
    end else begin
      if (pend_d) begin
        pend_d = 1'b0;
        if (pend_wr) begin
          if (wdata_q.size() == 0) chk("hwdata_unexpected", wdata_q.size(), 1);
          else begin m_d = wdata_q.pop_front(); chk("hwdata", d_hwdata, m_d); end
        end
      end
      if (d_htrans == 2'b10 && d_hready) begin
        if (addr_q.size() == 0) chk("addr_unexpected", addr_q.size(), 1);
        else begin
          m_a = addr_q.pop_front();
          chk("haddr", d_haddr, m_a.addr);
          chk("hwrite", {31'd0, d_hwrite}, {31'd0, m_a.wr});
          chk("hsize", {29'd0, d_hsize}, {30'd0, m_a.size});
        end
        pend_d  = 1'b1;
        pend_wr = d_hwrite;
      end
      if (wb_en) begin
        wb_seen++;
        if (wb_q.size() == 0) chk("wb_unexpected", wb_q.size(), 1);
        else begin
          m_w = wb_q.pop_front();
          chk("wb_rd", {27'd0, wb_rd}, {27'd0, m_w.rd});
          chk("wb_data", wb_data, m_w.data);
        end
      end
      if (bus_err) err_seen++;
    end
  end

  task automatic drive_req(input logic wr, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [4:0] rd, output int waited);
    req_write = wr; req_size = size; req_uns = uns;
    req_addr = addr; req_wdata = wdata; req_rd = rd;
    req_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!req_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    chk("req_accept", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic st(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wdata,
                    input logic [31:0] exp_addr, input logic [31:0] exp_wdata);
    int w;
    addr_q.push_back('{addr: exp_addr, wr: 1'b1, size: size});
    wdata_q.push_back(exp_wdata);
    drive_req(1'b1, size, 1'b0, addr, wdata, 5'd0, w);
  endtask

  task automatic ld(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                    input logic [4:0] rd, input logic [31:0] exp_addr,
                    input logic [31:0] exp_wb, output int waited);
    addr_q.push_back('{addr: exp_addr, wr: 1'b0, size: (size == 2'd3) ? 2'd2 : size});
    if (rd != 5'd0) wb_q.push_back('{rd: rd, data: exp_wb});
    drive_req(1'b0, size, uns, addr, 32'd0, rd, waited);
  endtask

  task automatic wait_empty(input string tag);
    int n = 0;
    while (sb_empty !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, {31'd0, sb_empty}, 32'd1);
  endtask

  initial begin
    int waited, seen;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_uns = 1'b0;
    req_addr = '0; req_wdata = '0; req_rd = '0;
    d_hready = 1'b1; d_hresp = 1'b0; d_hrdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_htrans", {30'd0, d_htrans}, 32'd0);
    chk("rst_haddr", d_haddr, 32'd0);
    chk("rst_hburst", {29'd0, d_hburst}, 32'd0);
    chk("rst_hprot", {28'd0, d_hprot}, 32'h3);
    chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
    chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
    chk("rst_sb_empty", {31'd0, sb_empty}, 32'd1);
    chk("rst_load_ready", {31'd0, req_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single word store, zero-wait bus
    st(32'h100, 2'd2, 32'hDEADBEEF, 32'h100, 32'hDEADBEEF);
    chk("store_nonseq", {30'd0, d_htrans}, 32'h2);
    @(posedge clk); #1;
    chk("store_sb_busy", {31'd0, sb_empty}, 32'd0);
    @(posedge clk); #1;
    chk("store_sb_empty_2cyc", {31'd0, sb_empty}, 32'd1);

    // Fill the buffer with the bus stalled, then a fifth store must wait for the first pop
    d_hready = 1'b0;
    st(32'h110, 2'd2, 32'h11111111, 32'h110, 32'h11111111);
    st(32'h112, 2'd0, 32'h000000AB, 32'h112, 32'hABABABAB);
    st(32'h116, 2'd1, 32'h00001234, 32'h116, 32'h12341234);
    st(32'h118, 2'd2, 32'h44444444, 32'h118, 32'h44444444);
    addr_q.push_back('{addr: 32'h11C, wr: 1'b1, size: 2'd2});
    wdata_q.push_back(32'h55555555);
    req_write = 1'b1; req_size = 2'd2; req_addr = 32'h11C; req_wdata = 32'h55555555;
    req_valid = 1'b1;
    @(negedge clk);
    chk("full_stall", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    d_hready = 1'b1;
    @(negedge clk);
    chk("full_stall_addr", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("full_pop_no_bypass", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("ready_after_pop", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_empty("drain_five");

    // Store then signed byte load: load stalls until the store drains
    d_hrdata = 32'h0000_8000;
    st(32'h200, 2'd2, 32'hCAFEF00D, 32'h200, 32'hCAFEF00D);
    ld(32'h101, 2'd0, 1'b0, 5'd5, 32'h101, 32'hFFFFFF80, waited);
    chk("load_stalled", {31'd0, waited > 0}, 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("load_latency_wb_en", {31'd0, wb_en}, 32'd1);
    chk("load_sb_byte", wb_data, 32'hFFFFFF80);

    // Unsigned half load, single-cycle strobe
    d_hrdata = 32'hABCD1234;
    ld(32'h102, 2'd1, 1'b1, 5'd7, 32'h102, 32'h0000ABCD, waited);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("lhu_wb_en", {31'd0, wb_en}, 32'd1);
    chk("lhu_data", wb_data, 32'h0000ABCD);
    @(posedge clk); #1;
    chk("lhu_wb_en_drop", {31'd0, wb_en}, 32'd0);

    // Load to x0 must not write back
    seen = wb_seen;
    ld(32'h104, 2'd2, 1'b0, 5'd0, 32'h104, 32'd0, waited);
    repeat (4) @(posedge clk);
    #1;
    chk("rd0_no_wb", wb_seen, seen);

    // Two-cycle ERROR response on a store
    st(32'h300, 2'd2, 32'h0BADF00D, 32'h300, 32'h0BADF00D);
    @(posedge clk); #1;
    d_hresp = 1'b1; d_hready = 1'b0;
    @(posedge clk); #1;
    chk("err_bus_err", {31'd0, bus_err}, 32'd1);
    chk("err_htrans_idle", {30'd0, d_htrans}, 32'd0);
    chk("err_popped", {31'd0, sb_empty}, 32'd1);
    d_hready = 1'b1;
    @(posedge clk); #1;
    chk("err_pulse_one_cycle", {31'd0, bus_err}, 32'd0);
    d_hresp = 1'b0;
    st(32'h304, 2'd2, 32'h600DF00D, 32'h304, 32'h600DF00D);
    wait_empty("after_err_store");
    chk("err_count", err_seen, 32'd1);

    // Misaligned word load
    d_hrdata = 32'h13572468;
`ifdef LSU_MISALIGN_TRAP_EN
    seen = err_seen;
    drive_req(1'b0, 2'd2, 1'b0, 32'h103, 32'd0, 5'd9, waited);
    repeat (4) @(posedge clk);
    #1;
    chk("trap_bus_err", err_seen, seen + 1);
`else
    ld(32'h103, 2'd2, 1'b0, 5'd9, 32'h100, 32'h13572468, waited);
    repeat (4) @(posedge clk);
    #1;
`endif

    // Reset in the middle of a stalled transfer discards the buffer
    d_hready = 1'b0;
    drive_req(1'b1, 2'd2, 1'b0, 32'h400, 32'h1, 5'd0, waited);
    drive_req(1'b1, 2'd2, 1'b0, 32'h404, 32'h2, 5'd0, waited);
    rst_n = 1'b0;
    #1;
    chk("midrst_htrans", {30'd0, d_htrans}, 32'd0);
    chk("midrst_sb_empty", {31'd0, sb_empty}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    d_hready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("midrst_idle", {30'd0, d_htrans}, 32'd0);

    chk("addr_q_left", addr_q.size(), 32'd0);
    chk("wdata_q_left", wdata_q.size(), 32'd0);
    chk("wb_q_left", wb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
